readout_sequencer: RTL and testbench
====================================

// Module: readout_sequencer
// PURPOSE
//  Run-level controller for the qubit readout chain (timing -> sampler -> multiplier -> integrator).
//  Arms a run of N shots and applies the trigger delay. Issues one start_collect pulse per shot to the
//  sampler and integrator, waits for iq_valid and hands each I/Q result downstream on a valid/ready port.
//  Gates config updates so parameters change only between runs. Replaces the standalone timing block.
// PARAMETERS
//  SHOT_W       16    width of num_shots / shot_count
//  DELAY_W      14    width of delay_time (cycles)
//  LEN_W        11    width of sample_length (cycles)
//  TIMEOUT_CYC  4096  extra cycles beyond sample_length to wait for iq_valid
// PORTS
//  clk100          in   1       system clock (100 MHz)
//  reset           in   1       synchronous, active-high
//  arm             in   1       pulse: start a run (IDLE only)
//  abort           in   1       pulse: terminate run from any state
//  num_shots       in   SHOT_W  shots per run, latched on arm
//  delay_time      in   DELAY_W trigger-to-start delay, latched on arm
//  sample_length   in   LEN_W   collection window, latched on arm
//  trigger         in   1       external experiment trigger (level; rising edge used)
//  cfg_update_req  in   1       request to load new config_params values
//  cfg_update_ack  out  1       1-cycle pulse: config load permitted (drives config_reset)
//  start_collect   out  1       1-cycle pulse to sampler/integrator
//  iq_valid        in   1       integrator result strobe
//  i_val, q_val    in   32      integrator result
//  res_valid       out  1       result held for downstream
//  res_ready       in   1       downstream accept
//  res_i, res_q    out  32      held result
//  busy            out  1       state != IDLE
//  shot_count      out  SHOT_W  completed (handshaken) shots this run
//  run_done        out  1       1-cycle pulse at end of run (normal, abort, timeout)
//  timeout_err     out  1       sticky; cleared on next accepted arm
//  trig_overrun    out  1       sticky: trigger edge outside WAIT_TRIG; cleared on next accepted arm
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; trig_d register set to 1 (trigger already high at release is no edge).
//  edge = trigger & ~trig_d (one registered stage).
//  FSM IDLE -> WAIT_TRIG -> DELAY -> WAIT_RES -> OUTPUT -> (WAIT_TRIG | IDLE).
//  IDLE:
//   - cfg_update_req -> cfg_update_ack next cycle; arm in the same cycle is dropped (cfg wins).
//   - arm latches num_shots/delay_time/sample_length, clears shot_count/timeout_err/trig_overrun.
//   - num_shots==0 -> run_done next cycle, stay IDLE; else -> WAIT_TRIG.
//  WAIT_TRIG: edge -> DELAY, counter loaded with delay_time.
//  DELAY: counter decrements; start_collect asserted on the cycle the counter reads 0, then -> WAIT_RES.
//   - Edge sampled at cycle T -> start_collect at T+1+delay_time (delay 0 -> T+1).
//  WAIT_RES:
//   - timer = sample_length + TIMEOUT_CYC, loaded at start_collect.
//   - iq_valid -> capture i_val/q_val into res_i/res_q, res_valid=1 next cycle, -> OUTPUT.
//   - timer expiry -> timeout_err=1, run_done, -> IDLE (no result emitted).
//   - iq_valid and expiry in the same cycle: iq_valid wins.
//  OUTPUT:
//   - res_valid held, res_i/res_q stable until res_valid & res_ready; then res_valid=0, shot_count+1.
//   - Then IDLE + run_done if shot_count+1 == num_shots, else WAIT_TRIG.
//   - Same-cycle ready is allowed: handshake on the first res_valid cycle is accepted.
//  Ignored inputs:
//   - iq_valid outside WAIT_RES: ignored.
//   - edge outside WAIT_TRIG (and not IDLE): ignored, sets trig_overrun.
//   - arm while busy: ignored.
//   - cfg_update_req while busy: stays pending until IDLE; ack issued then, before any new arm.
//  abort: from any non-IDLE state -> IDLE next cycle; res_valid, start_collect deasserted; run_done pulse;
//   shot_count retained. abort in IDLE is a no-op. reset mid-run = full reset, no run_done.
//  Arithmetic: all counters unsigned. Timeout sum is computed at width max(LEN_W, clog2(TIMEOUT_CYC))+1,
//   so no wrap. shot_count saturates at num_shots.
// STRUCTURE
//  readout_pkg:
//   - typedef enum logic [2:0] seq_state_t {IDLE, WAIT_TRIG, DELAY, WAIT_RES, OUTPUT}.
//   - width localparams shared with config_params/sampler/integrator.
//  Sub-module trig_edge_detect: register, reset-to-1, rising-edge pulse. All other logic is in one FSM.
// TESTING
//  - arm num_shots=3, delay=5, sample_length=20, iq_valid 22 cyc after start, res_ready=1
//    -> 3 start_collect pulses, each 6 cyc after trigger edge; 3 results; run_done once; shot_count=3.
//  - delay=0, edge at T -> start_collect at T+1.
//    Trigger held high through reset release -> no start_collect until next edge.
//  - res_ready low 10 cyc -> res_valid/res_i/res_q stable 10 cyc.
//    Extra trigger edge meanwhile -> trig_overrun=1; shot not double-counted.
//  - No iq_valid, sample_length=20, TIMEOUT_CYC=16 -> timeout_err and run_done 36 cyc after start_collect;
//    IDLE; next arm clears timeout_err.
//  - cfg_update_req during run -> ack only after run_done.
//    cfg_update_req and arm same cycle in IDLE -> ack, arm dropped, busy=0.
//  - abort in DELAY and in OUTPUT -> IDLE next cycle, run_done pulse, no start_collect, res_valid=0.
//    num_shots=0 -> run_done only.

Source files
------------

// File: rtl/readout_sequencer_pkg.sv
// Shared definitions for the qubit readout chain.
// Holds the default widths used by config_params, sampler, integrator and the run-level
// sequencer, the sequencer state encoding and a small constant helper.
package readout_sequencer_pkg;

  localparam int unsigned DefShotW      = 16;
  localparam int unsigned DefDelayW     = 14;
  localparam int unsigned DefLenW       = 11;
  localparam int unsigned DefTimeoutCyc = 4096;
  localparam int unsigned IqW           = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTrig,
    StDelay,
    StWaitRes,
    StOutput
  } seq_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/readout_sequencer_if.sv
// Downstream result channel of the readout sequencer (valid/ready with held I/Q payload).
//   res_valid : result held for downstream
//   res_ready : downstream accept
//   res_i/q   : held I/Q result, stable while res_valid is high
// master = sequencer side, slave = consumer side.
interface readout_sequencer_if;
  import readout_sequencer_pkg::*;

  logic           res_valid;
  logic           res_ready;
  logic [IqW-1:0] res_i;
  logic [IqW-1:0] res_q;

  modport master (output res_valid, output res_i, output res_q, input res_ready);
  modport slave  (input res_valid, input res_i, input res_q, output res_ready);

endinterface

// File: rtl/readout_sequencer_trig_edge_detect.sv
// Rising-edge detector for the external experiment trigger.
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset
//   trig_i : trigger level
//   edge_o : high for the cycle where trig_i is 1 and was 0 on the previous cycle
// The history register resets to 1 so a trigger already high at reset release is not an edge.
module readout_sequencer_trig_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic edge_o
);

  logic trig_d, trig_q;

  always_comb begin
    trig_d = trig_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q <= 1'b1;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign edge_o = trig_i & ~trig_q;

endmodule

// File: rtl/readout_sequencer.sv
// Run-level controller for the readout chain (timing -> sampler -> multiplier -> integrator).
// Arms a run of num_shots shots, waits for a trigger edge, applies delay_time, pulses
// start_collect, waits for iq_valid (with timeout) and hands each result downstream on res_if.
// Config updates are only acknowledged while idle.
// Ports:
//   clk100, reset                    : clock, synchronous active-high reset
//   arm, abort                       : run control pulses
//   num_shots, delay_time, sample_length : run parameters, latched on arm
//   trigger                          : external trigger level (rising edge used)
//   cfg_update_req / cfg_update_ack  : config load request / 1-cycle permit
//   start_collect                    : 1-cycle pulse to sampler/integrator
//   iq_valid, i_val, q_val           : integrator result
//   res_if (master)                  : held result, valid/ready
//   busy, shot_count, run_done       : status
//   timeout_err, trig_overrun        : sticky errors, cleared on accepted arm
module readout_sequencer
  import readout_sequencer_pkg::*;
#(
  parameter int unsigned ShotW      = DefShotW,
  parameter int unsigned DelayW     = DefDelayW,
  parameter int unsigned LenW       = DefLenW,
  parameter int unsigned TimeoutCyc = DefTimeoutCyc
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [ShotW-1:0]  num_shots,
  input  logic [DelayW-1:0] delay_time,
  input  logic [LenW-1:0]   sample_length,
  input  logic              trigger,
  input  logic              cfg_update_req,
  output logic              cfg_update_ack,
  output logic              start_collect,
  input  logic              iq_valid,
  input  logic [IqW-1:0]    i_val,
  input  logic [IqW-1:0]    q_val,
  readout_sequencer_if.master res_if,
  output logic              busy,
  output logic [ShotW-1:0]  shot_count,
  output logic              run_done,
  output logic              timeout_err,
  output logic              trig_overrun
);

  // Wide enough that sample_length + TimeoutCyc never wraps.
  localparam int unsigned SumW = max_u(LenW, $clog2(TimeoutCyc)) + 1;
  localparam logic [SumW-1:0] TimeoutExt = SumW'(TimeoutCyc);

  seq_state_t        state_d, state_q;
  logic [ShotW-1:0]  nshots_d, nshots_q;
  logic [DelayW-1:0] delay_d, delay_q;
  logic [LenW-1:0]   len_d, len_q;
  logic [DelayW-1:0] cnt_d, cnt_q;
  logic [SumW-1:0]   tmr_d, tmr_q;
  logic [IqW-1:0]    res_i_val_d, res_i_val_q;
  logic [IqW-1:0]    res_q_val_d, res_q_val_q;
  logic [ShotW-1:0]  shot_cnt_d, shot_cnt_q;
  logic              run_done_d, run_done_q;
  logic              tmo_err_d, tmo_err_q;
  logic              overrun_d, overrun_q;
  logic              cfg_pend_d, cfg_pend_q;
  logic              cfg_ack_d, cfg_ack_q;

  logic              trig_edge;
  logic [SumW-1:0]   tmr_limit;
  logic [ShotW:0]    shot_next;

  readout_sequencer_trig_edge_detect u_trig_edge (
    .clk_i  (clk100),
    .rst_i  (reset),
    .trig_i (trigger),
    .edge_o (trig_edge)
  );

  always_comb begin
    state_d     = state_q;
    nshots_d    = nshots_q;
    delay_d     = delay_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    res_i_val_d = res_i_val_q;
    res_q_val_d = res_q_val_q;
    shot_cnt_d  = shot_cnt_q;
    run_done_d  = 1'b0;
    tmo_err_d   = tmo_err_q;
    overrun_d   = overrun_q;
    cfg_pend_d  = cfg_pend_q;
    cfg_ack_d   = 1'b0;

    tmr_limit = SumW'(len_q) + TimeoutExt;
    shot_next = {1'b0, shot_cnt_q} + (ShotW + 1)'(1);

    if (trig_edge && (state_q != StIdle) && (state_q != StWaitTrig)) begin
      overrun_d = 1'b1;
    end
    // Requests during a run are remembered and served on the first idle cycle.
    if (cfg_update_req && (state_q != StIdle)) begin
      cfg_pend_d = 1'b1;
    end

    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      run_done_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          // A config request wins over an arm in the same cycle; the arm is dropped.
          if (cfg_update_req || cfg_pend_q) begin
            cfg_ack_d  = 1'b1;
            cfg_pend_d = 1'b0;
          end else if (arm) begin
            nshots_d   = num_shots;
            delay_d    = delay_time;
            len_d      = sample_length;
            shot_cnt_d = '0;
            tmo_err_d  = 1'b0;
            overrun_d  = 1'b0;
            if (num_shots == '0) begin
              run_done_d = 1'b1;
            end else begin
              state_d = StWaitTrig;
            end
          end
        end
        StWaitTrig: begin
          if (trig_edge) begin
            state_d = StDelay;
            cnt_d   = delay_q;
          end
        end
        StDelay: begin
          if (cnt_q == '0) begin
            state_d = StWaitRes;
            // tmr_q counts cycles since the start_collect pulse.
            tmr_d   = SumW'(1);
          end else begin
            cnt_d = cnt_q - DelayW'(1);
          end
        end
        StWaitRes: begin
          if (iq_valid) begin
            res_i_val_d = i_val;
            res_q_val_d = q_val;
            state_d     = StOutput;
          end else if ((tmr_q + SumW'(1)) >= tmr_limit) begin
            // run_done lands exactly tmr_limit cycles after start_collect.
            tmo_err_d  = 1'b1;
            run_done_d = 1'b1;
            state_d    = StIdle;
          end else begin
            tmr_d = tmr_q + SumW'(1);
          end
        end
        StOutput: begin
          if (res_if.res_ready) begin
            if (shot_cnt_q != nshots_q) begin
              shot_cnt_d = shot_next[ShotW-1:0];
            end
            if (shot_next >= {1'b0, nshots_q}) begin
              state_d    = StIdle;
              run_done_d = 1'b1;
            end else begin
              state_d = StWaitTrig;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q     <= StIdle;
      nshots_q    <= '0;
      delay_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      res_i_val_q <= '0;
      res_q_val_q <= '0;
      shot_cnt_q  <= '0;
      run_done_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_pend_q  <= 1'b0;
      cfg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nshots_q    <= nshots_d;
      delay_q     <= delay_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      res_i_val_q <= res_i_val_d;
      res_q_val_q <= res_q_val_d;
      shot_cnt_q  <= shot_cnt_d;
      run_done_q  <= run_done_d;
      tmo_err_q   <= tmo_err_d;
      overrun_q   <= overrun_d;
      cfg_pend_q  <= cfg_pend_d;
      cfg_ack_q   <= cfg_ack_d;
    end
  end

  // Decoded from registered state only, so the pulse covers the cycle the counter reads 0.
  assign start_collect    = (state_q == StDelay) && (cnt_q == '0);
  assign res_if.res_valid = (state_q == StOutput);
  assign res_if.res_i     = res_i_val_q;
  assign res_if.res_q     = res_q_val_q;
  assign busy             = (state_q != StIdle);
  assign shot_count       = shot_cnt_q;
  assign run_done         = run_done_q;
  assign timeout_err      = tmo_err_q;
  assign trig_overrun     = overrun_q;
  assign cfg_update_ack   = cfg_ack_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed self-checking bench for readout_sequencer (TimeoutCyc overridden to 16).
module tb_readout_sequencer;
  import readout_sequencer_pkg::*;

  localparam int unsigned ShotW      = 16;
  localparam int unsigned DelayW     = 14;
  localparam int unsigned LenW       = 11;
  localparam int unsigned TimeoutCyc = 16;

  logic              clk100 = 1'b0;
  logic              reset;
  logic              arm;
  logic              abort;
  logic [ShotW-1:0]  num_shots;
  logic [DelayW-1:0] delay_time;
  logic [LenW-1:0]   sample_length;
  logic              trigger;
  logic              cfg_update_req;
  logic              cfg_update_ack;
  logic              start_collect;
  logic              iq_valid;
  logic [31:0]       i_val;
  logic [31:0]       q_val;
  logic              busy;
  logic [ShotW-1:0]  shot_count;
  logic              run_done;
  logic              timeout_err;
  logic              trig_overrun;

  readout_sequencer_if res_if ();

  readout_sequencer #(
    .ShotW      (ShotW),
    .DelayW     (DelayW),
    .LenW       (LenW),
    .TimeoutCyc (TimeoutCyc)
  ) dut (
    .clk100         (clk100),
    .reset          (reset),
    .arm            (arm),
    .abort          (abort),
    .num_shots      (num_shots),
    .delay_time     (delay_time),
    .sample_length  (sample_length),
    .trigger        (trigger),
    .cfg_update_req (cfg_update_req),
    .cfg_update_ack (cfg_update_ack),
    .start_collect  (start_collect),
    .iq_valid       (iq_valid),
    .i_val          (i_val),
    .q_val          (q_val),
    .res_if         (res_if),
    .busy           (busy),
    .shot_count     (shot_count),
    .run_done       (run_done),
    .timeout_err    (timeout_err),
    .trig_overrun   (trig_overrun)
  );

  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse counters sampled mid-cycle.
  int sc_cnt  = 0;
  int rd_cnt  = 0;
  int ack_cnt = 0;
  always @(negedge clk100) begin
    if (start_collect === 1'b1)  sc_cnt  <= sc_cnt + 1;
    if (run_done === 1'b1)       rd_cnt  <= rd_cnt + 1;
    if (cfg_update_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic do_reset(input logic trig_lvl);
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = trig_lvl; cfg_update_req = 1'b0;
    iq_valid = 1'b0; i_val = '0; q_val = '0; res_if.res_ready = 1'b0;
    num_shots = '0; delay_time = '0; sample_length = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
  endtask

  task automatic arm_run(input logic [ShotW-1:0] ns, input logic [DelayW-1:0] d,
                         input logic [LenW-1:0] len);
    num_shots = ns; delay_time = d; sample_length = len; arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Raise trigger for one cycle; return cycles until start_collect is seen.
  task automatic fire(output int n);
    trigger = 1'b1;
    n = 0;
    do begin
      step();
      trigger = 1'b0;
      n++;
    end while (start_collect !== 1'b1 && n < 64);
  endtask

  task automatic deliver(input logic [31:0] iv, input logic [31:0] qv);
    iq_valid = 1'b1; i_val = iv; q_val = qv;
    step();
    iq_valid = 1'b0; i_val = 32'h0BAD_0BAD; q_val = 32'h0BAD_0BAD;
  endtask

  task automatic test_reset();
    int rd0;
    do_reset(1'b0);
    arm_run(16'd1, 14'd3, 11'd20);
    rd0 = rd_cnt;
    do_reset(1'b1);
    n_checks++; if (rd_cnt !== rd0) $display("FAIL reset_no_run_done: got %0d want %0d", rd_cnt, rd0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (start_collect !== 1'b0) $display("FAIL reset_start: got %b want 0", start_collect); else n_pass++;
    n_checks++; if (run_done !== 1'b0) $display("FAIL reset_run_done: got %b want 0", run_done); else n_pass++;
    n_checks++; if (shot_count !== '0) $display("FAIL reset_shot_count: got %0d want 0", shot_count); else n_pass++;
    n_checks++; if (res_if.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_if.res_valid); else n_pass++;
    n_checks++; if (res_if.res_i !== 32'h0) $display("FAIL reset_res_i: got %h want 0", res_if.res_i); else n_pass++;
    n_checks++; if (cfg_update_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", cfg_update_ack); else n_pass++;
    n_checks++; if ({timeout_err, trig_overrun} !== 2'b00) $display("FAIL reset_sticky: got %b want 00", {timeout_err, trig_overrun}); else n_pass++;
  endtask

  task automatic test_multi_shot();
    int n, sc0, rd0;
    logic [31:0] ei, eq;
    do_reset(1'b0);
    res_if.res_ready = 1'b1;
    sc0 = sc_cnt; rd0 = rd_cnt;
    arm_run(16'd3, 14'd5, 11'd20);
    for (int s = 0; s < 3; s++) begin
      fire(n);
      n_checks++; if (n !== 6) $display("FAIL shot%0d_start_latency: got %0d want 6", s, n); else n_pass++;
      repeat (22) step();
      ei = 32'h1000_0000 + 32'(s);
      eq = 32'hA000_0000 ^ 32'(s);
      deliver(ei, eq);
      n_checks++; if (res_if.res_valid !== 1'b1 || res_if.res_i !== ei || res_if.res_q !== eq)
        $display("FAIL shot%0d_result: got v=%b i=%h q=%h want v=1 i=%h q=%h", s, res_if.res_valid, res_if.res_i, res_if.res_q, ei, eq);
      else n_pass++;
      step();
      n_checks++; if (shot_count !== 16'(s + 1)) $display("FAIL shot%0d_count: got %0d want %0d", s, shot_count, s + 1); else n_pass++;
      n_checks++; if ({busy, run_done} !== ((s == 2) ? 2'b01 : 2'b10))
        $display("FAIL shot%0d_busy_done: got %b want %b", s, {busy, run_done}, (s == 2) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    step();
    n_checks++; if (sc_cnt - sc0 !== 3) $display("FAIL multi_start_pulses: got %0d want 3", sc_cnt - sc0); else n_pass++;
    n_checks++; if (rd_cnt - rd0 !== 1) $display("FAIL multi_run_done_pulses: got %0d want 1", rd_cnt - rd0); else n_pass++;
  endtask

  task automatic test_delay_zero();
    int n, sc0;
    do_reset(1'b1);
    res_if.res_ready = 1'b1;
    arm_run(16'd1, 14'd0, 11'd20);
    sc0 = sc_cnt;
    repeat (5) step();
    n_checks++; if (sc_cnt !== sc0) $display("FAIL held_trig_no_start: got %0d want %0d", sc_cnt, sc0); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL held_trig_busy: got %b want 1", busy); else n_pass++;
    trigger = 1'b0;
    step();
    fire(n);
    n_checks++; if (n !== 1) $display("FAIL delay0_latency: got %0d want 1", n); else n_pass++;
    repeat (3) step();
    deliver(32'h0000_1111, 32'h0000_2222);
    step();
    n_checks++; if ({busy, shot_count} !== {1'b0, 16'd1}) $display("FAIL delay0_end: got busy=%b cnt=%0d want busy=0 cnt=1", busy, shot_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n, sc0, stable;
    do_reset(1'b0);
    arm_run(16'd2, 14'd2, 11'd20);
    fire(n);
    n_checks++; if (n !== 3) $display("FAIL bp_start_latency: got %0d want 3", n); else n_pass++;
    repeat (4) step();
    deliver(32'hDEAD_BEEF, 32'h0123_4567);
    sc0 = sc_cnt;
    stable = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_if.res_valid === 1'b1 && res_if.res_i === 32'hDEAD_BEEF && res_if.res_q === 32'h0123_4567)
        stable++;
      if (c == 2) trigger = 1'b1;
      if (c == 4) trigger = 1'b0;
      if (c == 6) begin iq_valid = 1'b1; i_val = 32'h5555_5555; q_val = 32'h6666_6666; end
      if (c == 7) iq_valid = 1'b0;
      step();
    end
    n_checks++; if (stable !== 10) $display("FAIL bp_held_stable: got %0d want 10", stable); else n_pass++;
    n_checks++; if (trig_overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", trig_overrun); else n_pass++;
    res_if.res_ready = 1'b1;
    step();
    res_if.res_ready = 1'b0;
    n_checks++; if ({res_if.res_valid, busy, shot_count} !== {1'b0, 1'b1, 16'd1})
      $display("FAIL bp_accept: got v=%b busy=%b cnt=%0d want v=0 busy=1 cnt=1", res_if.res_valid, busy, shot_count);
    else n_pass++;
    repeat (4) step();
    n_checks++; if (sc_cnt !== sc0 || shot_count !== 16'd1)
      $display("FAIL bp_no_double: got starts=%0d cnt=%0d want starts=%0d cnt=1", sc_cnt, shot_count, sc0);
    else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if ({run_done, busy, shot_count} !== {1'b1, 1'b0, 16'd1})
      $display("FAIL bp_abort_retain: got done=%b busy=%b cnt=%0d want done=1 busy=0 cnt=1", run_done, busy, shot_count);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset(1'b0);
    arm_run(16'd1, 14'd0, 11'd20);
    fire(n);
    n = 0;
    do begin
      step();
      n++;
    end while (run_done !== 1'b1 && n < 80);
    n_checks++; if (n !== 36) $display("FAIL timeout_latency: got %0d want 36", n); else n_pass++;
    n_checks++; if ({timeout_err, busy, res_if.res_valid} !== 3'b100)
      $display("FAIL timeout_state: got err/busy/valid=%b want 100", {timeout_err, busy, res_if.res_valid});
    else n_pass++;
    arm_run(16'd1, 14'd0, 11'd20);
    n_checks++; if ({timeout_err, busy} !== 2'b01) $display("FAIL timeout_clear_on_arm: got err/busy=%b want 01", {timeout_err, busy}); else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_cfg_gating();
    int n, ack0;
    do_reset(1'b0);
    res_if.res_ready = 1'b1;
    ack0 = ack_cnt;
    arm_run(16'd1, 14'd1, 11'd20);
    cfg_update_req = 1'b1;
    step();
    cfg_update_req = 1'b0;
    fire(n);
    repeat (5) step();
    deliver(32'h0000_00AA, 32'h0000_00BB);
    step();
    n_checks++; if (run_done !== 1'b1) $display("FAIL cfg_run_done: got %b want 1", run_done); else n_pass++;
    n_checks++; if (ack_cnt !== ack0 || cfg_update_ack !== 1'b0)
      $display("FAIL cfg_ack_held: got acks=%0d ack=%b want acks=%0d ack=0", ack_cnt, cfg_update_ack, ack0);
    else n_pass++;
    step();
    n_checks++; if (cfg_update_ack !== 1'b1) $display("FAIL cfg_ack_after_run: got %b want 1", cfg_update_ack); else n_pass++;
    step();
    num_shots = 16'd1; arm = 1'b1; cfg_update_req = 1'b1;
    step();
    arm = 1'b0; cfg_update_req = 1'b0;
    n_checks++; if ({cfg_update_ack, busy} !== 2'b10) $display("FAIL cfg_wins_arm: got ack/busy=%b want 10", {cfg_update_ack, busy}); else n_pass++;
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL cfg_arm_dropped: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_abort();
    int n, sc0, rd0;
    do_reset(1'b0);
    sc0 = sc_cnt;
    arm_run(16'd1, 14'd10, 11'd20);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if ({busy, run_done, start_collect} !== 3'b010)
      $display("FAIL abort_delay: got busy/done/start=%b want 010", {busy, run_done, start_collect});
    else n_pass++;
    repeat (12) step();
    n_checks++; if (sc_cnt !== sc0) $display("FAIL abort_delay_no_start: got %0d want %0d", sc_cnt, sc0); else n_pass++;
    res_if.res_ready = 1'b0;
    arm_run(16'd2, 14'd0, 11'd20);
    fire(n);
    step();
    deliver(32'h1234_5678, 32'h8765_4321);
    n_checks++; if (res_if.res_valid !== 1'b1) $display("FAIL abort_out_valid: got %b want 1", res_if.res_valid); else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if ({res_if.res_valid, busy, run_done, shot_count} !== {3'b001, 16'd0})
      $display("FAIL abort_output: got v/busy/done=%b cnt=%0d want 001 cnt=0", {res_if.res_valid, busy, run_done}, shot_count);
    else n_pass++;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if ({run_done, busy} !== 2'b00) $display("FAIL abort_idle_noop: got done/busy=%b want 00", {run_done, busy}); else n_pass++;
    rd0 = rd_cnt; sc0 = sc_cnt;
    arm_run(16'd0, 14'd0, 11'd20);
    n_checks++; if ({run_done, busy} !== 2'b10) $display("FAIL zero_shots: got done/busy=%b want 10", {run_done, busy}); else n_pass++;
    repeat (3) step();
    n_checks++; if (rd_cnt - rd0 !== 1 || sc_cnt !== sc0)
      $display("FAIL zero_shots_pulses: got done=%0d starts=%0d want done=1 starts=0", rd_cnt - rd0, sc_cnt - sc0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_multi_shot();
    test_delay_zero();
    test_backpressure();
    test_timeout();
    test_cfg_gating();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
